// File: rtl/frameblock_buffer_pkg.sv
// Shared types and defaults for the double-buffered frameblock store.
package frameblock_buffer_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ID_W   = 7;
    localparam int unsigned BANKS      = 2;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        FULL = 2'd1,
        READ = 2'd2
    } bank_state_t;

endpackage

// File: rtl/frameblock_ram.sv
// Simple dual-port pixel memory: one write port, one registered read port.
// The bank select is the address MSB.
module frameblock_ram
    import frameblock_buffer_pkg::*;
#(
    parameter int unsigned AW = DEF_ADDR_W + 1,
    parameter int unsigned DW = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frameblock_buffer.sv
// Double-buffered frameblock store between renderer (fill side) and LCD driver
// (read side); blocks are handed over in commit order with their IDs.
module frameblock_buffer
    import frameblock_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ID_W   = DEF_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_we,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_commit,
    input  logic [ID_W-1:0]   fill_id,
    output logic              fill_ready,
    output logic              fill_overflow,
    input  logic [ADDR_W-1:0] frameblock_addr,
    output logic [DATA_W-1:0] frameblock_data,
    output logic [ID_W-1:0]   frameblock_id,
    input  logic              frameblock_next,
    output logic              frameblock_ready
);

    bank_state_t     state_q [BANKS];
    bank_state_t     state_d [BANKS];
    logic [ID_W-1:0] id_q    [BANKS];
    logic [ID_W-1:0] id_d    [BANKS];
    logic            fill_bank_q, fill_bank_d;
    logic            read_bank_q, read_bank_d;
    logic            overflow_q, overflow_d;
    logic [ID_W-1:0] fb_id_q;
    logic            any_read, take_bank;
    logic            any_read_d, pend_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                state_q[1'(b)] <= FREE;
                id_q[1'(b)]    <= '0;
            end
            fill_bank_q <= 1'b0;
            read_bank_q <= 1'b0;
            overflow_q  <= 1'b0;
            fb_id_q     <= '0;
        end else begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                state_q[1'(b)] <= state_d[1'(b)];
                id_q[1'(b)]    <= id_d[1'(b)];
            end
            fill_bank_q <= fill_bank_d;
            read_bank_q <= read_bank_d;
            overflow_q  <= overflow_d;
            if (state_d[pend_d] == FULL) begin
                fb_id_q <= id_d[pend_d];
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < BANKS; b++) begin
            state_d[1'(b)] = state_q[1'(b)];
            id_d[1'(b)]    = id_q[1'(b)];
        end
        fill_bank_d = fill_bank_q;
        read_bank_d = read_bank_q;
        overflow_d  = overflow_q;
        any_read    = (state_q[0] == READ) || (state_q[1] == READ);
        take_bank   = any_read ? ~read_bank_q : read_bank_q;

        if (frameblock_next) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                if (state_q[1'(b)] == READ) begin
                    state_d[1'(b)] = FREE;
                end
            end
            if (state_q[take_bank] == FULL) begin
                state_d[take_bank] = READ;
                read_bank_d        = take_bank;
            end else if (any_read) begin
                // Idle reader keeps read_bank on the next block it will take.
                read_bank_d = ~read_bank_q;
            end
        end

        if (fill_commit) begin
            if (fill_ready) begin
                state_d[fill_bank_q] = FULL;
                id_d[fill_bank_q]    = fill_id;
                fill_bank_d          = ~fill_bank_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (fill_we && !fill_ready) begin
            overflow_d = 1'b1;
        end

        any_read_d = (state_d[0] == READ) || (state_d[1] == READ);
        pend_d     = any_read_d ? ~read_bank_d : read_bank_d;
    end

    always_comb begin
        fill_ready       = (state_q[fill_bank_q] == FREE);
        frameblock_ready = (state_q[0] == FULL) || (state_q[1] == FULL);
        fill_overflow    = overflow_q;
        frameblock_id    = fb_id_q;
    end

    frameblock_ram #(
        .AW(ADDR_W + 1),
        .DW(DATA_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (fill_we && fill_ready),
        .waddr({fill_bank_q, fill_addr}),
        .wdata(fill_data),
        .raddr({read_bank_q, frameblock_addr}),
        .rdata(frameblock_data)
    );

endmodule

// File: tb/tb_frameblock_buffer.sv
// Bench for frameblock_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frameblock_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_we;
    logic [9:0]  fill_addr;
    logic [15:0] fill_data;
    logic        fill_commit;
    logic [6:0]  fill_id;
    logic        fill_ready;
    logic        fill_overflow;
    logic [9:0]  frameblock_addr;
    logic [15:0] frameblock_data;
    logic [6:0]  frameblock_id;
    logic        frameblock_next;
    logic        frameblock_ready;

    always #5 clk = ~clk;

    frameblock_buffer #(
        .ADDR_W(10),
        .DATA_W(16),
        .ID_W  (7)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fill_we         (fill_we),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .fill_commit     (fill_commit),
        .fill_id         (fill_id),
        .fill_ready      (fill_ready),
        .fill_overflow   (fill_overflow),
        .frameblock_addr (frameblock_addr),
        .frameblock_data (frameblock_data),
        .frameblock_id   (frameblock_id),
        .frameblock_next (frameblock_next),
        .frameblock_ready(frameblock_ready)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: committed blocks wait in a FIFO; the reader owns at most one bank.
    typedef struct packed {
        logic       bank;
        logic [6:0] id;
    } blk_t;

    blk_t        pq[$];
    logic        m_fb, m_rd_valid, m_rd_bank, m_ovf, m_dchk;
    logic [6:0]  m_id;
    logic [15:0] m_dexp;
    bit          m_init = 1'b0;
    logic [15:0] mmem [2048];
    bit          mwr  [2048];

    function automatic bit m_fill_ready();
        if (m_rd_valid && m_rd_bank == m_fb) return 1'b0;
        foreach (pq[i]) if (pq[i].bank == m_fb) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit   fr;
        int   ra, wa;
        blk_t nb;
        if (!rst) begin
            pq.delete();
            m_fb = 1'b0; m_rd_valid = 1'b0; m_rd_bank = 1'b0; m_ovf = 1'b0;
            m_id = '0; m_dchk = 1'b1; m_dexp = '0; m_init = 1'b1;
        end else begin
            fr = m_fill_ready();
            ra = int'({m_rd_bank, frameblock_addr});
            m_dchk = m_rd_valid && mwr[ra];
            m_dexp = mmem[ra];
            if (fill_we) begin
                if (fr) begin
                    wa = int'({m_fb, fill_addr});
                    mmem[wa] = fill_data;
                    mwr[wa]  = 1'b1;
                end else m_ovf = 1'b1;
            end
            if (frameblock_next) begin
                m_rd_valid = 1'b0;
                if (pq.size() > 0) begin
                    m_rd_bank  = pq[0].bank;
                    m_rd_valid = 1'b1;
                    void'(pq.pop_front());
                end
            end
            if (fill_commit) begin
                if (fr) begin
                    nb.bank = m_fb;
                    nb.id   = fill_id;
                    pq.push_back(nb);
                    m_fb = ~m_fb;
                end else m_ovf = 1'b1;
            end
            if (pq.size() > 0) m_id = pq[0].id;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("fill_ready", 32'(fill_ready), 32'(m_fill_ready()));
            check("fill_overflow", 32'(fill_overflow), 32'(m_ovf));
            check("frameblock_ready", 32'(frameblock_ready), 32'(pq.size() > 0));
            check("frameblock_id", 32'(frameblock_id), 32'(m_id));
            if (m_dchk) check("frameblock_data", 32'(frameblock_data), 32'(m_dexp));
        end
    end

    task automatic write_px(input logic [9:0] a, input logic [15:0] d);
        fill_we = 1'b1; fill_addr = a; fill_data = d;
        @(negedge clk);
        fill_we = 1'b0;
    endtask

    task automatic fill_range(input int n, input logic [15:0] x);
        for (int i = 0; i < n; i++) write_px(10'(i), 16'(i) ^ x);
    endtask

    task automatic commit(input logic [6:0] id);
        fill_commit = 1'b1; fill_id = id;
        @(negedge clk);
        fill_commit = 1'b0;
    endtask

    task automatic next_op();
        frameblock_next = 1'b1;
        @(negedge clk);
        frameblock_next = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            frameblock_addr = 10'(i);
            @(negedge clk);
        end
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_fill_ready"}, 32'(fill_ready), 32'd1);
        check({tag, "_overflow"}, 32'(fill_overflow), 32'd0);
        check({tag, "_fb_ready"}, 32'(frameblock_ready), 32'd0);
        check({tag, "_fb_id"}, 32'(frameblock_id), 32'd0);
        check({tag, "_fb_data"}, 32'(frameblock_data), 32'd0);
    endtask

    initial begin
        rst = 1'b1; fill_we = 1'b0; fill_addr = '0; fill_data = '0;
        fill_commit = 1'b0; fill_id = '0; frameblock_addr = '0; frameblock_next = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_literals("rst");

        // Full block with data = addr, id 5
        fill_range(1024, 16'h0000);
        commit(7'd5);
        check("t1_fb_ready", 32'(frameblock_ready), 32'd1);
        check("t1_fb_id", 32'(frameblock_id), 32'd5);
        check("t1_fill_ready", 32'(fill_ready), 32'd1);
        next_op();
        frameblock_addr = 10'h3FF;
        @(negedge clk);
        check("t1_data_3ff", 32'(frameblock_data), 32'h03FF);
        sweep(1024);

        // Two pending blocks, overflow, in-order delivery
        next_op();
        fill_range(64, 16'h5500);
        commit(7'd5);
        fill_range(64, 16'h6600);
        commit(7'd6);
        check("t2_fill_ready", 32'(fill_ready), 32'd0);
        write_px(10'h010, 16'hDEAD);
        check("t2_overflow", 32'(fill_overflow), 32'd1);
        check("t2_first_id", 32'(frameblock_id), 32'd5);
        next_op();
        check("t2_second_id", 32'(frameblock_id), 32'd6);
        check("t2_still_ready", 32'(frameblock_ready), 32'd1);
        sweep(64);
        frameblock_addr = 10'h010;
        @(negedge clk);
        check("t2_no_corrupt", 32'(frameblock_data), 32'h5510);
        next_op();
        check("t2_drained", 32'(frameblock_ready), 32'd0);
        check("t2_fill_free", 32'(fill_ready), 32'd1);
        check("t2_id_held", 32'(frameblock_id), 32'd6);
        sweep(64);

        // Simultaneous next and commit
        fill_range(32, 16'h7700);
        check("t3_pre_ready", 32'(frameblock_ready), 32'd0);
        fill_commit = 1'b1; fill_id = 7'd7; frameblock_next = 1'b1;
        @(negedge clk);
        fill_commit = 1'b0; frameblock_next = 1'b0;
        check("t3_fb_ready", 32'(frameblock_ready), 32'd1);
        check("t3_fill_ready", 32'(fill_ready), 32'd1);
        check("t3_fb_id", 32'(frameblock_id), 32'd7);
        next_op();
        sweep(32);

        // Next with nothing pending only releases the read bank
        next_op();
        check("t4_fb_ready", 32'(frameblock_ready), 32'd0);
        check("t4_fill_ready", 32'(fill_ready), 32'd1);
        commit(7'd8);
        commit(7'd9);
        check("t4_both_full", 32'(fill_ready), 32'd0);
        check("t4_id", 32'(frameblock_id), 32'd8);
        next_op();
        next_op();

        // Write and commit in the same cycle
        fill_we = 1'b1; fill_addr = 10'h000; fill_data = 16'hABCD;
        fill_commit = 1'b1; fill_id = 7'd11;
        @(negedge clk);
        fill_we = 1'b0; fill_commit = 1'b0;
        check("t5_id", 32'(frameblock_id), 32'd11);
        next_op();
        frameblock_addr = 10'h000;
        @(negedge clk);
        check("t5_data", 32'(frameblock_data), 32'hABCD);

        // Asynchronous reset mid-fill and mid-read
        fill_range(8, 16'hB000);
        commit(7'd12);
        next_op();
        fill_range(8, 16'hC000);
        frameblock_addr = 10'h005;
        fill_we = 1'b1; fill_addr = 10'h009; fill_data = 16'hC009;
        #2 rst = 1'b0;
        #1 reset_literals("t6_async");
        fill_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fill_range(16, 16'hE000);
        commit(7'd13);
        check("t6_fb_ready", 32'(frameblock_ready), 32'd1);
        check("t6_fb_id", 32'(frameblock_id), 32'd13);
        next_op();
        frameblock_addr = 10'h003;
        @(negedge clk);
        check("t6_bank0_data", 32'(frameblock_data), 32'hE003);
        sweep(16);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
